// File: rtl/cond_pkg.sv
// Shared types for the vector conditional unit: condition codes and NZCV flag layout.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_NV   = 4'b0000,
        COND_AL   = 4'b0001,
        COND_EQ   = 4'b0010,
        COND_NE   = 4'b0011,
        COND_MI   = 4'b0100,
        COND_PL   = 4'b0101,
        COND_CS   = 4'b0110,
        COND_CC   = 4'b0111,
        COND_VS   = 4'b1000,
        COND_VC   = 4'b1001,
        COND_GE   = 4'b1010,
        COND_LT   = 4'b1011,
        COND_GT   = 4'b1100,
        COND_LE   = 4'b1101,
        COND_RSV0 = 4'b1110,
        COND_RSV1 = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flag_t;

endpackage

// File: rtl/cond_lane_eval.sv
// Combinational evaluation of one condition code against one lane's NZCV nibble.
module cond_lane_eval
    import cond_pkg::*;
(
    input  flag_t       flags_i,
    input  logic [3:0]  cond_i,
    output logic        hit_o
);

    logic n, z, c, v;

    always_comb begin
        n = flags_i[FLAG_N];
        z = flags_i[FLAG_Z];
        c = flags_i[FLAG_C];
        v = flags_i[FLAG_V];
        hit_o = 1'b0;
        case (cond_e'(cond_i))
            COND_NV:   hit_o = 1'b0;
            COND_AL:   hit_o = 1'b1;
            COND_EQ:   hit_o = z;
            COND_NE:   hit_o = !z;
            COND_MI:   hit_o = n;
            COND_PL:   hit_o = !n;
            COND_CS:   hit_o = c;
            COND_CC:   hit_o = !c;
            COND_VS:   hit_o = v;
            COND_VC:   hit_o = !v;
            COND_GE:   hit_o = (n == v);
            COND_LT:   hit_o = (n != v);
            COND_GT:   hit_o = !z && (n == v);
            COND_LE:   hit_o = z || (n != v);
            // Reserved encodings behave as "never".
            COND_RSV0: hit_o = 1'b0;
            COND_RSV1: hit_o = 1'b0;
            default:   hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit_vec.sv
// Multi-lane conditional unit: per-lane flag bank, lane mask, ANY/ALL branch reduction.
// Define COND_BYPASS_EN to forward same-cycle flag writes into the evaluation.
module cond_unit_vec
    import cond_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int FLAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          flag_we,
    input  logic [LANES*FLAG_W-1:0]   flags_in,
    input  logic                      mask_we,
    input  logic [LANES-1:0]          mask_in,
    input  logic                      cond_valid,
    input  logic [3:0]                cond,
    input  logic                      red_all,
    output logic                      jmp_valid,
    output logic                      jmp_sel,
    output logic [LANES-1:0]          pred_mask,
    output logic [LANES*FLAG_W-1:0]   flags_q
);

    // Handshake: cond_valid is a one-shot request with no backpressure; every cycle it is
    // high produces exactly one jmp_valid pulse on the following cycle (no ready signal).

    logic [FLAG_W-1:0] flag_bank_q [LANES];
    logic [FLAG_W-1:0] flag_bank_d [LANES];
    logic [FLAG_W-1:0] eval_flags  [LANES];
    logic [LANES-1:0]  mask_q, mask_d;
    logic [LANES-1:0]  lane_true;
    logic [LANES-1:0]  hit;
    logic              taken;
    logic              jmp_valid_q, jmp_valid_d;
    logic              jmp_sel_q, jmp_sel_d;
    logic [LANES-1:0]  pred_q, pred_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef COND_BYPASS_EN
        assign eval_flags[i] = flag_we[i] ? flags_in[i*FLAG_W +: FLAG_W] : flag_bank_q[i];
`else
        assign eval_flags[i] = flag_bank_q[i];
`endif
        assign flags_q[i*FLAG_W +: FLAG_W] = flag_bank_q[i];

        cond_lane_eval u_eval (
            .flags_i (eval_flags[i]),
            .cond_i  (cond),
            .hit_o   (lane_true[i])
        );
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            flag_bank_d[i] = flag_we[i] ? flags_in[i*FLAG_W +: FLAG_W] : flag_bank_q[i];
        end
        mask_d = mask_we ? mask_in : mask_q;

        // The stored mask governs this decision; a mask write lands for the next one.
        hit   = lane_true & mask_q;
        taken = red_all ? ((hit == mask_q) && (|mask_q)) : (|hit);

        jmp_valid_d = cond_valid;
        jmp_sel_d   = cond_valid ? taken : 1'b0;
        pred_d      = cond_valid ? hit : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                flag_bank_q[i] <= '0;
            end
            mask_q      <= '1;
            jmp_valid_q <= 1'b0;
            jmp_sel_q   <= 1'b0;
            pred_q      <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                flag_bank_q[i] <= flag_bank_d[i];
            end
            mask_q      <= mask_d;
            jmp_valid_q <= jmp_valid_d;
            jmp_sel_q   <= jmp_sel_d;
            pred_q      <= pred_d;
        end
    end

    assign jmp_valid = jmp_valid_q;
    assign jmp_sel   = jmp_sel_q;
    assign pred_mask = pred_q;

endmodule

// File: tb/tb_cond_unit_vec.sv
// Directed bench for cond_unit_vec with LANES=4; expectations hand-computed per vector.
module tb_cond_unit_vec;

    localparam int LANES  = 4;
    localparam int FLAG_W = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES-1:0]        flag_we;
    logic [LANES*FLAG_W-1:0] flags_in;
    logic                    mask_we;
    logic [LANES-1:0]        mask_in;
    logic                    cond_valid;
    logic [3:0]              cond;
    logic                    red_all;
    logic                    jmp_valid;
    logic                    jmp_sel;
    logic [LANES-1:0]        pred_mask;
    logic [LANES*FLAG_W-1:0] flags_q;

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboard entry: {jmp_sel, pred_mask}
    logic [LANES:0] exp_q[$];

    cond_unit_vec #(.LANES(LANES), .FLAG_W(FLAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flag_we    (flag_we),
        .flags_in   (flags_in),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .cond_valid (cond_valid),
        .cond       (cond),
        .red_all    (red_all),
        .jmp_valid  (jmp_valid),
        .jmp_sel    (jmp_sel),
        .pred_mask  (pred_mask),
        .flags_q    (flags_q)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst        = 1'b0;
        flag_we    = '0;
        flags_in   = '0;
        mask_we    = 1'b0;
        mask_in    = '0;
        cond_valid = 1'b0;
        cond       = 4'h0;
        red_all    = 1'b0;
    endtask

    task automatic write_state(input logic [3:0] we, input logic [15:0] f,
                               input logic mwe, input logic [3:0] m);
        clear_inputs();
        flag_we  = we;
        flags_in = f;
        mask_we  = mwe;
        mask_in  = m;
        tick();
        clear_inputs();
    endtask

    // Issue one evaluation; compare the registered decision against the scoreboard.
    task automatic eval_chk(input string tag, input logic [3:0] c, input logic ra,
                            input logic exp_sel, input logic [3:0] exp_pred);
        logic [LANES:0] e;
        cond_valid = 1'b1;
        cond       = c;
        red_all    = ra;
        exp_q.push_back({exp_sel, exp_pred});
        tick();
        cond_valid = 1'b0;
        e = exp_q.pop_front();
        check_eq({tag, ".valid"}, 32'(jmp_valid), 32'd1);
        check_eq({tag, ".sel"},   32'(jmp_sel),   32'(e[LANES]));
        check_eq({tag, ".pred"},  32'(pred_mask), 32'(e[LANES-1:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        check_eq("rst.flags", 32'(flags_q), 32'h0);
        check_eq("rst.valid", 32'(jmp_valid), 32'd0);
        check_eq("rst.sel",   32'(jmp_sel), 32'd0);
        check_eq("rst.pred",  32'(pred_mask), 32'h0);
        // Reset mask is all ones: ALWAYS under ALL covers every lane.
        eval_chk("rst.mask", 4'b0001, 1'b1, 1'b1, 4'b1111);

        tick();
        check_eq("idle.valid", 32'(jmp_valid), 32'd0);
        check_eq("idle.pred",  32'(pred_mask), 32'h0);

        // Write lane0 Z, then hold with flag_we=0
        write_state(4'b0001, 16'h0004, 1'b0, 4'h0);
        check_eq("wr.flags", 32'(flags_q), 32'h0004);
        flags_in = '0;
        eval_chk("hold.eq", 4'b0010, 1'b0, 1'b1, 4'b0001);
        check_eq("hold.flags", 32'(flags_q), 32'h0004);

        // Z on lanes 3,1,0
        write_state(4'b1111, 16'h4044, 1'b0, 4'h0);
        check_eq("all.flags", 32'(flags_q), 32'h4044);
        eval_chk("any.eq", 4'b0010, 1'b0, 1'b1, 4'b1011);
        eval_chk("all.eq", 4'b0010, 1'b1, 1'b0, 4'b1011);
        // Mask written in the same cycle as evaluation: old mask 1111 still applies.
        mask_we = 1'b1;
        mask_in = 4'b1011;
        eval_chk("all.mwe", 4'b0010, 1'b1, 1'b0, 4'b1011);
        mask_we = 1'b0;
        eval_chk("all.m1011", 4'b0010, 1'b1, 1'b1, 4'b1011);

        // Signed: lane0 N=1,V=0; mask only lane0
        write_state(4'b0001, 16'h4048, 1'b1, 4'b0001);
        eval_chk("sgn.lt",  4'b1011, 1'b0, 1'b1, 4'b0001);
        eval_chk("sgn.ge",  4'b1010, 1'b0, 1'b0, 4'b0000);
        eval_chk("sgn.r14", 4'b1110, 1'b0, 1'b0, 4'b0000);
        eval_chk("sgn.r15", 4'b1111, 1'b0, 1'b0, 4'b0000);
        eval_chk("sgn.gt",  4'b1100, 1'b0, 1'b0, 4'b0000);
        eval_chk("sgn.le",  4'b1101, 1'b0, 1'b1, 4'b0001);
        eval_chk("sgn.mi",  4'b0100, 1'b1, 1'b1, 4'b0001);
        eval_chk("sgn.vc",  4'b1001, 1'b1, 1'b1, 4'b0001);

        // Empty mask
        write_state(4'b0000, 16'h0, 1'b1, 4'b0000);
        eval_chk("empty.any", 4'b0001, 1'b0, 1'b0, 4'b0000);
        eval_chk("empty.all", 4'b0001, 1'b1, 1'b0, 4'b0000);

        // Same-cycle write and evaluate: stored Z=0, new Z=1 on lane0
        write_state(4'b1111, 16'h0000, 1'b1, 4'b1111);
        flag_we  = 4'b0001;
        flags_in = 16'h0004;
`ifdef COND_BYPASS_EN
        eval_chk("byp.eq", 4'b0010, 1'b0, 1'b1, 4'b0001);
`else
        eval_chk("byp.eq", 4'b0010, 1'b0, 1'b0, 4'b0000);
`endif
        flag_we  = '0;
        flags_in = '0;
        check_eq("byp.flags", 32'(flags_q), 32'h0004);
        eval_chk("byp.next", 4'b0010, 1'b0, 1'b1, 4'b0001);

        // Reset with a pending evaluation; rst wins over the flag write too
        cond_valid = 1'b1;
        cond       = 4'b0001;
        flag_we    = 4'b1111;
        flags_in   = 16'hFFFF;
        mask_we    = 1'b1;
        mask_in    = 4'b0000;
        rst        = 1'b1;
        tick();
        clear_inputs();
        check_eq("mid.valid", 32'(jmp_valid), 32'd0);
        check_eq("mid.sel",   32'(jmp_sel), 32'd0);
        check_eq("mid.pred",  32'(pred_mask), 32'h0);
        check_eq("mid.flags", 32'(flags_q), 32'h0);
        eval_chk("mid.mask", 4'b0001, 1'b1, 1'b1, 4'b1111);

        check_eq("sb.empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
